// File: rtl/exec_pkg.sv
// Shared execute-stage definitions: M-op encodings, FSM states, tag widths and
// the single-cycle compute function used by both scalu and mcalu.
package exec_pkg;

  localparam int ROBID_W = 7;
  localparam int RD_W    = 6;

  typedef enum logic [2:0] {
    MOP_MUL    = 3'd0,
    MOP_MULH   = 3'd1,
    MOP_MULHSU = 3'd2,
    MOP_MULHU  = 3'd3,
    MOP_DIV    = 3'd4,
    MOP_DIVU   = 3'd5,
    MOP_REM    = 3'd6,
    MOP_REMU   = 3'd7
  } mop_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mcalu_state_e;

  // op[4:3]: 00 arithmetic/logic/shift, 01 compare/pass, 10 pass op1, 11 M-op (not handled here)
  function automatic logic [31:0] sc_compute(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    r = a;
    case (op[4:3])
      2'b00: begin
        case (op[2:0])
          3'd0: r = a + b;
          3'd1: r = a - b;
          3'd2: r = a & b;
          3'd3: r = a | b;
          3'd4: r = a ^ b;
          3'd5: r = a << b[4:0];
          3'd6: r = a >> b[4:0];
          3'd7: r = 32'($signed(a) >>> b[4:0]);
        endcase
      end
      2'b01: begin
        case (op[2:0])
          3'd0:    r = {31'd0, $signed(a) < $signed(b)};
          3'd1:    r = {31'd0, a < b};
          3'd2:    r = b;
          default: r = a;
        endcase
      end
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mcalu_div.sv
// Restoring radix-2 unsigned divider: one quotient bit per cycle, 32 cycles per divide.
module mcalu_div
  import exec_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clr,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] dvs;
  logic [4:0]  cnt;
  logic [32:0] trial;

  // quotient doubles as the dividend shift register; its MSB feeds the partial remainder
  assign trial = {remainder, quotient[31]} - {1'b0, dvs};
  assign done  = busy && (cnt == 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= 1'b0;
      cnt       <= 5'd0;
      dvs       <= 32'd0;
      quotient  <= 32'd0;
      remainder <= 32'd0;
    end else if (clr) begin
      busy <= 1'b0;
      cnt  <= 5'd0;
    end else if (start) begin
      busy      <= 1'b1;
      cnt       <= 5'd31;
      dvs       <= divisor;
      quotient  <= dividend;
      remainder <= 32'd0;
    end else if (busy) begin
      if (!trial[32]) begin
        remainder <= trial[31:0];
        quotient  <= {quotient[30:0], 1'b1};
      end else begin
        remainder <= {remainder[30:0], quotient[31]};
        quotient  <= {quotient[30:0], 1'b0};
      end
      cnt <= cnt - 5'd1;
      if (cnt == 5'd0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mcalu.sv
// Multi-cycle ALU execute unit: iterative RV32M mul/div plus single-cycle ops,
// one op in flight, result held on a valid/stall writeback port.
//   state | meaning
//   IDLE  | ready to accept an issue
//   MUL   | multiply latency countdown
//   DIV   | divider iterating
//   FIX   | apply quotient/remainder signs
//   DONE  | result valid, waiting for writeback
module mcalu
  import exec_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exers_mcalu_issue,
  input  logic [4:0]         exers_mcalu_op,
  input  logic [ROBID_W-1:0] exers_robid,
  input  logic [RD_W-1:0]    exers_rd,
  input  logic [31:0]        exers_op1,
  input  logic [31:0]        exers_op2,
  output logic               mcalu_stall,
  output logic               mcalu_wb_valid,
  output logic [ROBID_W-1:0] mcalu_wb_robid,
  output logic [RD_W-1:0]    mcalu_wb_rd,
  output logic [31:0]        mcalu_wb_result,
  input  logic               wb_mcalu_stall,
  input  logic               rob_flush
);

  function automatic logic [31:0] mul_calc(input logic [2:0] mop, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [32:0]        ax, bx;
    logic signed [63:0] p;
    ax = (mop == MOP_MULHU) ? {1'b0, a} : {a[31], a};
    bx = (mop == MOP_MUL || mop == MOP_MULH) ? {b[31], b} : {1'b0, b};
    p  = $signed(ax) * $signed(bx);
    return (mop == MOP_MUL) ? p[31:0] : p[63:32];
  endfunction

  mcalu_state_e state;
  logic [4:0]   cnt;
  logic [2:0]   mop_q;
  logic [31:0]  op1_q, op2_q;
  logic         neg_q, neg_r;

  logic         accept, is_mop, is_div, sgn_div, is_rem, div_by0, div_ovf, div_start;
  logic [31:0]  abs1, abs2, special_res;
  logic         div_busy, div_done;
  logic [31:0]  div_q, div_r;

  assign mcalu_stall    = (state != ST_IDLE);
  assign mcalu_wb_valid = (state == ST_DONE);

  assign accept      = exers_mcalu_issue && !mcalu_stall && !rob_flush;
  assign is_mop      = (exers_mcalu_op[4:3] == 2'b11);
  assign is_div      = is_mop && exers_mcalu_op[2];
  assign sgn_div     = is_div && !exers_mcalu_op[0];
  assign is_rem      = exers_mcalu_op[1];
  assign div_by0     = (exers_op2 == 32'd0);
  assign div_ovf     = sgn_div && (exers_op1 == 32'h8000_0000) && (exers_op2 == 32'hFFFF_FFFF);
  assign abs1        = (sgn_div && exers_op1[31]) ? -exers_op1 : exers_op1;
  assign abs2        = (sgn_div && exers_op2[31]) ? -exers_op2 : exers_op2;
  assign special_res = div_by0 ? (is_rem ? exers_op1 : 32'hFFFF_FFFF)
                               : (is_rem ? 32'd0 : 32'h8000_0000);
  assign div_start   = accept && is_div && !div_by0 && !div_ovf;

  mcalu_div u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .clr       (rob_flush),
    .dividend  (abs1),
    .divisor   (abs2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      cnt             <= 5'd0;
      mop_q           <= 3'd0;
      op1_q           <= 32'd0;
      op2_q           <= 32'd0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      mcalu_wb_robid  <= '0;
      mcalu_wb_rd     <= '0;
      mcalu_wb_result <= 32'd0;
    end else if (rob_flush) begin
      state <= ST_IDLE;
      cnt   <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mcalu_wb_robid <= exers_robid;
            mcalu_wb_rd    <= exers_rd;
            mop_q          <= exers_mcalu_op[2:0];
            op1_q          <= exers_op1;
            op2_q          <= exers_op2;
            neg_q          <= sgn_div && (exers_op1[31] ^ exers_op2[31]);
            neg_r          <= sgn_div && exers_op1[31];
            if (!is_mop) begin
              mcalu_wb_result <= sc_compute(exers_mcalu_op, exers_op1, exers_op2);
              state           <= ST_DONE;
            end else if (!is_div) begin
              if (MUL_LAT == 1) begin
                mcalu_wb_result <= mul_calc(exers_mcalu_op[2:0], exers_op1, exers_op2);
                state           <= ST_DONE;
              end else begin
                cnt   <= 5'(MUL_LAT - 1);
                state <= ST_MUL;
              end
            end else if (div_by0 || div_ovf) begin
              mcalu_wb_result <= special_res;
              state           <= ST_DONE;
            end else begin
              cnt   <= 5'd31;
              state <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            mcalu_wb_result <= mul_calc(mop_q, op1_q, op2_q);
            state           <= ST_DONE;
          end
        end
        ST_DIV: begin
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
          if (div_done) state <= ST_FIX;
          else if (!div_busy) state <= ST_IDLE;  // divider lost its op; never hang here
        end
        ST_FIX: begin
          mcalu_wb_result <= mop_q[1] ? (neg_r ? -div_r : div_r) : (neg_q ? -div_q : div_q);
          state           <= ST_DONE;
        end
        ST_DONE: begin
          if (!wb_mcalu_stall) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
